// File: rtl/ex_stage.sv
// MIPS execute stage: ID->EX register, ALU, store address/data, HI/LO with
// single-cycle multiply and a 32-iteration restoring divider.
module ex_stage (
  input  logic         clk,
  input  logic         rst,
  input  logic [5:0]   stall,
  input  logic [158:0] id_to_ex_bus,
  output logic [75:0]  ex_to_mem_bus,
  output logic [37:0]  ex_to_rf_bus,
  output logic         data_sram_en,
  output logic [3:0]   data_sram_wen,
  output logic [31:0]  data_sram_addr,
  output logic [31:0]  data_sram_wdata,
  output logic         ex_is_load,
  output logic         stallreq_for_ex
);

  localparam logic STOP   = 1'b1;
  localparam logic NOSTOP = 1'b0;

  typedef enum logic [1:0] {DIV_IDLE, DIV_RUN, DIV_DONE} div_state_e;

  logic [158:0] ex_q;

  always_ff @(posedge clk) begin
    if (!rst)                                      ex_q <= '0;
    else if (stall[2] == STOP && stall[3] == NOSTOP) ex_q <= '0;
    else if (stall[2] == NOSTOP)                   ex_q <= id_to_ex_bus;
  end

  logic [31:0] pc, inst, rdata1, rdata2;
  logic [11:0] alu_op;
  logic [2:0]  sel_src1;
  logic [3:0]  sel_src2, dram_wen;
  logic        dram_en, rf_we, sel_rf_res;
  logic [4:0]  rf_waddr;

  assign {pc, inst, alu_op, sel_src1, sel_src2, dram_en, dram_wen, rf_we,
          rf_waddr, sel_rf_res, rdata1, rdata2} = ex_q;

  logic [31:0] imm_sext, imm_zext, op1, op2;
  assign imm_sext = {{16{inst[15]}}, inst[15:0]};
  assign imm_zext = {16'b0, inst[15:0]};
  assign op1 = ({32{sel_src1[0]}} & rdata1) | ({32{sel_src1[1]}} & pc)
             | ({32{sel_src1[2]}} & {27'b0, inst[10:6]});
  assign op2 = ({32{sel_src2[0]}} & rdata2) | ({32{sel_src2[1]}} & imm_sext)
             | ({32{sel_src2[2]}} & 32'h8) | ({32{sel_src2[3]}} & imm_zext);

  logic op_add, op_sub, op_slt, op_sltu, op_and, op_nor, op_or, op_xor;
  logic op_sll, op_srl, op_sra, op_lui;
  assign {op_add, op_sub, op_slt, op_sltu, op_and, op_nor, op_or, op_xor,
          op_sll, op_srl, op_sra, op_lui} = alu_op;

  logic [31:0] sra_res, alu_res;
  assign sra_res = $signed(op2) >>> op1[4:0];
  assign alu_res = ({32{op_add}}  & (op1 + op2))
                 | ({32{op_sub}}  & (op1 - op2))
                 | ({32{op_slt}}  & {31'b0, $signed(op1) < $signed(op2)})
                 | ({32{op_sltu}} & {31'b0, op1 < op2})
                 | ({32{op_and}}  & (op1 & op2))
                 | ({32{op_nor}}  & ~(op1 | op2))
                 | ({32{op_or}}   & (op1 | op2))
                 | ({32{op_xor}}  & (op1 ^ op2))
                 | ({32{op_sll}}  & (op2 << op1[4:0]))
                 | ({32{op_srl}}  & (op2 >> op1[4:0]))
                 | ({32{op_sra}}  & sra_res)
                 | ({32{op_lui}}  & {op2[15:0], 16'b0});

  logic special;
  logic is_mult, is_multu, is_div, is_divu, is_mfhi, is_mflo, is_mthi, is_mtlo;
  assign special  = (inst[31:26] == 6'b0);
  assign is_mult  = special && inst[5:0] == 6'h18;
  assign is_multu = special && inst[5:0] == 6'h19;
  assign is_div   = special && inst[5:0] == 6'h1A;
  assign is_divu  = special && inst[5:0] == 6'h1B;
  assign is_mfhi  = special && inst[5:0] == 6'h10;
  assign is_mflo  = special && inst[5:0] == 6'h12;
  assign is_mthi  = special && inst[5:0] == 6'h11;
  assign is_mtlo  = special && inst[5:0] == 6'h13;

  // Sign-extending to 64 bits makes one unsigned multiply serve both forms.
  logic [63:0] mul_a, mul_b, prod;
  assign mul_a = {{32{is_mult & rdata1[31]}}, rdata1};
  assign mul_b = {{32{is_mult & rdata2[31]}}, rdata2};
  assign prod  = mul_a * mul_b;

  div_state_e  state_q;
  logic [4:0]  cnt_q;
  logic [31:0] rem_q, quo_q, dsr_q, hi_q, lo_q;
  logic        neg_quo_q, neg_rem_q;

  logic [32:0] shifted, sub33;
  logic        ge;
  logic [31:0] rem_d, quo_d, a_mag, b_mag, quo_fix, rem_fix;
  assign shifted = {rem_q, quo_q[31]};
  assign sub33   = shifted - {1'b0, dsr_q};
  assign ge      = shifted >= {1'b0, dsr_q};
  assign rem_d   = ge ? sub33[31:0] : shifted[31:0];
  assign quo_d   = {quo_q[30:0], ge};
  assign a_mag   = (is_div && rdata1[31]) ? -rdata1 : rdata1;
  assign b_mag   = (is_div && rdata2[31]) ? -rdata2 : rdata2;
  assign quo_fix = neg_quo_q ? -quo_q : quo_q;
  assign rem_fix = neg_rem_q ? -rem_q : rem_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= DIV_IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dsr_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      if (is_mult || is_multu) {hi_q, lo_q} <= prod;
      if (is_mthi) hi_q <= rdata1;
      if (is_mtlo) lo_q <= rdata1;
      case (state_q)
        DIV_IDLE: if (is_div || is_divu) begin
          rem_q     <= '0;
          quo_q     <= a_mag;
          dsr_q     <= b_mag;
          neg_quo_q <= is_div & (rdata1[31] ^ rdata2[31]);
          neg_rem_q <= is_div & rdata1[31];
          cnt_q     <= '0;
          state_q   <= DIV_RUN;
        end
        DIV_RUN: begin
          rem_q <= rem_d;
          quo_q <= quo_d;
          cnt_q <= cnt_q + 5'd1;
          if (cnt_q == 5'd31) state_q <= DIV_DONE;
        end
        DIV_DONE: begin
          hi_q    <= rem_fix;
          lo_q    <= quo_fix;
          state_q <= DIV_IDLE;
        end
        default: state_q <= DIV_IDLE;
      endcase
    end
  end

  logic [31:0] ex_result;
  assign ex_result = is_mfhi ? hi_q : (is_mflo ? lo_q : alu_res);

  assign ex_to_mem_bus   = {pc, dram_en, dram_wen, sel_rf_res, rf_we, rf_waddr, ex_result};
  assign ex_to_rf_bus    = {rf_we, rf_waddr, ex_result};
  assign data_sram_en    = dram_en;
  assign data_sram_wen   = dram_wen;
  assign data_sram_addr  = rdata1 + imm_sext;
  assign data_sram_wdata = rdata2;
  assign ex_is_load      = dram_en & ~|dram_wen;
  // Low in DONE so the stall controller releases the held divide.
  assign stallreq_for_ex = (state_q == DIV_IDLE && (is_div || is_divu)) || state_q == DIV_RUN;

  logic unused_bits;
  assign unused_bits = ^{inst[25:16], stall[5:4], stall[1:0], sub33[32]};

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: reset, ALU/forwarding, memory ports, HI/LO,
// divide latency, reset during a divide and bubble insertion.
module tb_ex_stage;

  logic         clk;
  logic         rst;
  logic [5:0]   stall;
  logic [158:0] id_to_ex_bus;
  logic [75:0]  ex_to_mem_bus;
  logic [37:0]  ex_to_rf_bus;
  logic         data_sram_en;
  logic [3:0]   data_sram_wen;
  logic [31:0]  data_sram_addr;
  logic [31:0]  data_sram_wdata;
  logic         ex_is_load;
  logic         stallreq_for_ex;

  int cmp_cnt = 0;
  int mis_cnt = 0;
  int ncyc;

  localparam logic [11:0] ADD = 12'h800, SLT = 12'h200, SLTU = 12'h100;
  localparam logic [11:0] SRA = 12'h002, LUI = 12'h001, NOP = 12'h000;
  localparam logic [31:0] MFHI = 32'h0000_1810, MFLO = 32'h0000_1812;

  ex_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .id_to_ex_bus    (id_to_ex_bus),
    .ex_to_mem_bus   (ex_to_mem_bus),
    .ex_to_rf_bus    (ex_to_rf_bus),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .ex_is_load      (ex_is_load),
    .stallreq_for_ex (stallreq_for_ex)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [158:0] mk(
    input logic [31:0] pc, input logic [31:0] inst, input logic [11:0] op,
    input logic [2:0] s1, input logic [3:0] s2, input logic den,
    input logic [3:0] wen, input logic we, input logic [4:0] wa,
    input logic res, input logic [31:0] r1, input logic [31:0] r2);
    return {pc, inst, op, s1, s2, den, wen, we, wa, res, r1, r2};
  endfunction

  task automatic chk(input string tag, input logic [75:0] obs, input logic [75:0] exp);
    cmp_cnt++;
    assert (obs === exp) else begin
      mis_cnt++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_div(output int n);
    n = 0;
    while (stallreq_for_ex && n < 100) begin
      n++;
      stall = 6'b001111;
      step();
    end
    stall = 6'b000000;
  endtask

  initial begin
    rst = 1'b0;
    stall = 6'b000000;
    id_to_ex_bus = mk(32'h1234_5678, 32'h0000_001A, ADD, 3'b001, 4'b0001,
                      1'b1, 4'hF, 1'b1, 5'd9, 1'b1, 32'hFFFF_FFF9, 32'd2);
    step();
    step();
    chk("rst_mem_bus", ex_to_mem_bus, '0);
    chk("rst_rf_bus", {38'b0, ex_to_rf_bus}, '0);
    chk("rst_sram", {data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata}, '0);
    chk("rst_load_stallreq", {ex_is_load, stallreq_for_ex}, '0);

    rst = 1'b1;
    id_to_ex_bus = mk(32'h0, MFHI, NOP, 3'b000, 4'b0000, 1'b0, 4'h0, 1'b1, 5'd3, 1'b0, 32'h0, 32'h0);
    step();
    chk("mfhi_after_rst", ex_to_rf_bus, {1'b1, 5'd3, 32'h0});

    id_to_ex_bus = mk(32'h0, 32'h0000_4021, ADD, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd8, 1'b0,
                      32'h7FFF_FFFF, 32'd1);
    step();
    chk("addu_wrap_fwd", ex_to_rf_bus, {1'b1, 5'd8, 32'h8000_0000});

    id_to_ex_bus = mk(32'h0, 32'h0000_402A, SLT, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd8, 1'b0,
                      32'h7FFF_FFFF, 32'd1);
    step();
    chk("slt", ex_to_rf_bus[31:0], 32'd0);

    id_to_ex_bus = mk(32'h0, 32'h0000_402B, SLTU, 3'b001, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd8, 1'b0,
                      32'd1, 32'hFFFF_FFFF);
    step();
    chk("sltu", ex_to_rf_bus[31:0], 32'd1);

    id_to_ex_bus = mk(32'hBFC0_0010, 32'h0C00_0000, ADD, 3'b010, 4'b0100, 1'b0, 4'h0, 1'b1, 5'd31,
                      1'b0, 32'h0, 32'h0);
    step();
    chk("jal_link", ex_to_mem_bus, {32'hBFC0_0010, 1'b0, 4'h0, 1'b0, 1'b1, 5'd31, 32'hBFC0_0018});

    id_to_ex_bus = mk(32'h0, 32'hAC00_FFFC, ADD, 3'b001, 4'b0010, 1'b1, 4'hF, 1'b0, 5'd0, 1'b0,
                      32'h0000_1000, 32'hDEAD_BEEF);
    step();
    chk("sw_ports", {data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata, ex_is_load},
        {1'b1, 4'hF, 32'h0000_0FFC, 32'hDEAD_BEEF, 1'b0});

    id_to_ex_bus = mk(32'h0, 32'h8C00_0008, ADD, 3'b001, 4'b0010, 1'b1, 4'h0, 1'b1, 5'd4, 1'b1,
                      32'h0000_2000, 32'h0);
    step();
    chk("lw_ports", {data_sram_addr, ex_is_load}, {32'h0000_2008, 1'b1});

    id_to_ex_bus = mk(32'h0, 32'h0000_0103, SRA, 3'b100, 4'b0001, 1'b0, 4'h0, 1'b1, 5'd5, 1'b0,
                      32'h0, 32'h8000_0000);
    step();
    chk("sra", ex_to_rf_bus[31:0], 32'hF800_0000);

    id_to_ex_bus = mk(32'h0, 32'h3C00_1234, LUI, 3'b000, 4'b1000, 1'b0, 4'h0, 1'b1, 5'd6, 1'b0,
                      32'h0, 32'h0);
    step();
    chk("lui", ex_to_rf_bus[31:0], 32'h1234_0000);

    id_to_ex_bus = mk(32'h0, 32'h0000_0018, NOP, 3'b000, 4'b0000, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0,
                      32'hFFFF_FFFE, 32'd3);
    step();
    id_to_ex_bus = mk(32'h0, MFHI, NOP, 3'b000, 4'b0000, 1'b0, 4'h0, 1'b1, 5'd3, 1'b0, 32'h0, 32'h0);
    step();
    chk("mult_mfhi", ex_to_rf_bus[31:0], 32'hFFFF_FFFF);
    id_to_ex_bus = mk(32'h0, MFLO, NOP, 3'b000, 4'b0000, 1'b0, 4'h0, 1'b1, 5'd3, 1'b0, 32'h0, 32'h0);
    step();
    chk("mult_mflo", ex_to_rf_bus[31:0], 32'hFFFF_FFFA);

    id_to_ex_bus = mk(32'h0, 32'h0000_001A, NOP, 3'b000, 4'b0000, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0,
                      32'hFFFF_FFF9, 32'd2);
    step();
    run_div(ncyc);
    chk("div_stall_cycles", 76'(ncyc), 76'd33);
    id_to_ex_bus = mk(32'h0, MFLO, NOP, 3'b000, 4'b0000, 1'b0, 4'h0, 1'b1, 5'd3, 1'b0, 32'h0, 32'h0);
    step();
    chk("div_lo", ex_to_rf_bus[31:0], 32'hFFFF_FFFD);
    id_to_ex_bus = mk(32'h0, MFHI, NOP, 3'b000, 4'b0000, 1'b0, 4'h0, 1'b1, 5'd3, 1'b0, 32'h0, 32'h0);
    step();
    chk("div_hi", ex_to_rf_bus[31:0], 32'hFFFF_FFFF);

    id_to_ex_bus = mk(32'h0, 32'h0000_001B, NOP, 3'b000, 4'b0000, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0,
                      32'd5, 32'd0);
    step();
    run_div(ncyc);
    chk("divu0_stall_cycles", 76'(ncyc), 76'd33);
    id_to_ex_bus = mk(32'h0, MFLO, NOP, 3'b000, 4'b0000, 1'b0, 4'h0, 1'b1, 5'd3, 1'b0, 32'h0, 32'h0);
    step();
    chk("divu0_lo", ex_to_rf_bus[31:0], 32'hFFFF_FFFF);
    id_to_ex_bus = mk(32'h0, MFHI, NOP, 3'b000, 4'b0000, 1'b0, 4'h0, 1'b1, 5'd3, 1'b0, 32'h0, 32'h0);
    step();
    chk("divu0_hi", ex_to_rf_bus[31:0], 32'd5);

    id_to_ex_bus = mk(32'h0, 32'h0000_001B, NOP, 3'b000, 4'b0000, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0,
                      32'd1000, 32'd3);
    step();
    stall = 6'b001111;
    for (int i = 0; i < 10; i++) step();
    chk("mid_div_stallreq", {75'b0, stallreq_for_ex}, 76'd1);
    rst = 1'b0;
    step();
    chk("rst_abort_stallreq", {75'b0, stallreq_for_ex}, 76'd0);
    chk("rst_abort_bus", ex_to_mem_bus, '0);
    rst = 1'b1;
    stall = 6'b000000;
    id_to_ex_bus = mk(32'h0, MFHI, NOP, 3'b000, 4'b0000, 1'b0, 4'h0, 1'b1, 5'd3, 1'b0, 32'h0, 32'h0);
    step();
    chk("rst_abort_hi", ex_to_rf_bus[31:0], 32'h0);

    id_to_ex_bus = mk(32'h0, 32'h0000_001B, NOP, 3'b000, 4'b0000, 1'b0, 4'h0, 1'b0, 5'd0, 1'b0,
                      32'd100, 32'd7);
    step();
    run_div(ncyc);
    chk("divu_stall_cycles", 76'(ncyc), 76'd33);
    id_to_ex_bus = mk(32'h0, MFLO, NOP, 3'b000, 4'b0000, 1'b0, 4'h0, 1'b1, 5'd3, 1'b0, 32'h0, 32'h0);
    step();
    chk("divu_lo", ex_to_rf_bus[31:0], 32'd14);
    id_to_ex_bus = mk(32'h0, MFHI, NOP, 3'b000, 4'b0000, 1'b0, 4'h0, 1'b1, 5'd3, 1'b0, 32'h0, 32'h0);
    step();
    chk("divu_hi", ex_to_rf_bus[31:0], 32'd2);

    id_to_ex_bus = mk(32'h0, 32'h8C00_0008, ADD, 3'b001, 4'b0010, 1'b1, 4'h0, 1'b1, 5'd4, 1'b1,
                      32'h0000_2000, 32'h0);
    step();
    chk("pre_bubble", {74'b0, ex_to_rf_bus[37], data_sram_en}, 76'b11);
    stall = 6'b000111;
    step();
    chk("bubble_we_en", {74'b0, ex_to_rf_bus[37], data_sram_en}, 76'b00);
    chk("bubble_bus", ex_to_mem_bus, '0);
    stall = 6'b000000;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, mis_cnt);
    $finish;
  end

endmodule
